// File: rtl/hsi_mse_min_search.sv
// hsi_mse_min_search
// Tracks the smallest MSE (and the arrival index that produced it) over a
// programmed number of MSE results, then pulses done with the best match.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start             one-cycle pulse: begin a new search, latch library_size
//                     (and threshold when compiled in); aborts a running one
//   library_size      results in this search, saturates to LIBRARY_SIZE
//   mse, mse_valid    incoming MSE result and its single-cycle qualifier
//   threshold         max accepted MSE (only with HSI_MSE_THRESHOLD_EN)
//   busy              high while searching
//   done              one-cycle pulse when the result is final
//   min_mse/min_index best MSE so far and its 0-based arrival index
//   match             result qualifier, held until the next start
//
// Optional feature macro: HSI_MSE_THRESHOLD_EN (adds threshold port; match
// then also requires min_mse <= threshold).
module hsi_mse_min_search #(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned LIBRARY_SIZE = 16,
    parameter int unsigned LIBRARY_ADDR = $clog2(LIBRARY_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LIBRARY_ADDR:0]   library_size,
    input  logic [WORD_WIDTH-1:0]   mse,
    input  logic                    mse_valid,
`ifdef HSI_MSE_THRESHOLD_EN
    input  logic [WORD_WIDTH-1:0]   threshold,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [WORD_WIDTH-1:0]   min_mse,
    output logic [LIBRARY_ADDR-1:0] min_index,
    output logic                    match
);

    localparam int unsigned SIZE_W = LIBRARY_ADDR + 1;
    localparam logic [SIZE_W-1:0]     SIZE_MAX = SIZE_W'(LIBRARY_SIZE);
    localparam logic [WORD_WIDTH-1:0] MSE_INIT = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SIZE_W-1:0]       count_q, count_d;
    logic [SIZE_W-1:0]       size_q, size_d;
    logic [SIZE_W-1:0]       size_sat;
    logic [WORD_WIDTH-1:0]   min_mse_d;
    logic [LIBRARY_ADDR-1:0] min_index_d;
    logic                    match_d;
    logic                    busy_d;
    logic                    done_d;
`ifdef HSI_MSE_THRESHOLD_EN
    logic [WORD_WIDTH-1:0]   thr_q, thr_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        size_d      = size_q;
        min_mse_d   = min_mse;
        min_index_d = min_index;
        match_d     = match;
`ifdef HSI_MSE_THRESHOLD_EN
        thr_d       = thr_q;
`endif
        size_sat    = (library_size > SIZE_MAX) ? SIZE_MAX : library_size;

        if (start) begin
            // start wins in every state; a same-cycle mse_valid is discarded
            count_d     = '0;
            size_d      = size_sat;
            min_mse_d   = MSE_INIT;
            min_index_d = '0;
            match_d     = 1'b0;
`ifdef HSI_MSE_THRESHOLD_EN
            thr_d       = threshold;
`endif
            state_d     = (size_sat == '0) ? DONE : SEARCH;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (mse_valid) begin
                        // strict compare so ties keep the earlier index
                        if (mse < min_mse) begin
                            min_mse_d   = mse;
                            min_index_d = LIBRARY_ADDR'(count_q);
                        end
                        count_d = count_q + SIZE_W'(1);
                        if (count_q == size_q - SIZE_W'(1)) begin
                            state_d = DONE;
`ifdef HSI_MSE_THRESHOLD_EN
                            match_d = (min_mse_d <= thr_q) && (size_q != '0);
`else
                            match_d = (size_q != '0);
`endif
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end

        busy_d = (state_d == SEARCH);
        done_d = (state_d == DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            size_q    <= '0;
            min_mse   <= '0;
            min_index <= '0;
            match     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef HSI_MSE_THRESHOLD_EN
            thr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            size_q    <= size_d;
            min_mse   <= min_mse_d;
            min_index <= min_index_d;
            match     <= match_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef HSI_MSE_THRESHOLD_EN
            thr_q     <= thr_d;
`endif
        end
    end

endmodule

// File: tb/tb_hsi_mse_min_search.sv
// Self-checking bench for hsi_mse_min_search: expected results are queued as
// stimulus is driven, done pulses are captured by a monitor and compared.
module tb_hsi_mse_min_search;

    localparam int unsigned WW = 32;
    localparam int unsigned LS = 16;
    localparam int unsigned LA = 4;
    localparam int unsigned SW = LA + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] library_size = '0;
    logic [WW-1:0] mse = '0;
    logic          mse_valid = 1'b0;
`ifdef HSI_MSE_THRESHOLD_EN
    logic [WW-1:0] threshold = '0;
`endif
    logic          busy;
    logic          done;
    logic [WW-1:0] min_mse;
    logic [LA-1:0] min_index;
    logic          match;

    typedef struct {
        logic [WW-1:0] mse;
        logic [LA-1:0] idx;
        logic          match;
        int            cyc;
    } res_t;

    res_t          exp_q[$];
    res_t          obs_q[$];
    res_t          mon_r;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            last_cyc = 0;
    logic [WW-1:0] vals [0:31];

    hsi_mse_min_search #(
        .WORD_WIDTH  (WW),
        .LIBRARY_SIZE(LS),
        .LIBRARY_ADDR(LA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .library_size(library_size),
        .mse         (mse),
        .mse_valid   (mse_valid),
`ifdef HSI_MSE_THRESHOLD_EN
        .threshold   (threshold),
`endif
        .busy        (busy),
        .done        (done),
        .min_mse     (min_mse),
        .min_index   (min_index),
        .match       (match)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // capture every done pulse with the cycle it appeared in
    always @(negedge clk) begin
        if (done) begin
            mon_r.mse   = min_mse;
            mon_r.idx   = min_index;
            mon_r.match = match;
            mon_r.cyc   = cyc;
            obs_q.push_back(mon_r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // model the search over vals[], drive it, and queue the expected result
    task automatic run_search(input int sz, input int nvals, input int gap);
        res_t e;
        int   eff;
        eff   = (sz > int'(LS)) ? int'(LS) : sz;
        e.mse = '1;
        e.idx = '0;
        for (int i = 0; i < eff; i++) begin
            if (vals[i] < e.mse) begin
                e.mse = vals[i];
                e.idx = LA'(i);
            end
        end
`ifdef HSI_MSE_THRESHOLD_EN
        e.match = (eff > 0) && (e.mse <= threshold);
`else
        e.match = (eff > 0);
`endif
        start = 1'b1;
        library_size = SW'(sz);
        step();
        start = 1'b0;
        last_cyc = cyc;
        for (int i = 0; i < nvals; i++) begin
            mse = vals[i];
            mse_valid = 1'b1;
            step();
            last_cyc = cyc;
            mse_valid = 1'b0;
            repeat (gap) step();
        end
        e.cyc = last_cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_obs(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() > 0) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (obs_q.size() > 0) got = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (min_mse !== '0)     begin failures++; $display("FAIL reset_min_mse got=%0h exp=0", min_mse); end
        checks++; if (min_index !== '0)   begin failures++; $display("FAIL reset_min_index got=%0d exp=0", min_index); end
        checks++; if (match !== 1'b0)     begin failures++; $display("FAIL reset_match got=%0b exp=0", match); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        res_t e, o;
        bit   got;
        vals[0] = 500; vals[1] = 200; vals[2] = 300; vals[3] = 900;
        start = 1'b1; library_size = SW'(4); step(); start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%0b exp=1", busy); end
        step();
        // restart immediately (same search again) so the queued model lines up
        exp_q.delete();
        run_search(4, 4, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%0b exp=0", busy); end
        wait_obs(20, got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL basic timeout: no done"); void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.mse !== 32'd200 || o.idx !== 4'd1 || o.match !== 1'b1 || o.cyc !== e.cyc)
                begin failures++; $display("FAIL basic got mse=%0d idx=%0d match=%0b cyc=%0d exp mse=200 idx=1 match=1 cyc=%0d", o.mse, o.idx, o.match, o.cyc, e.cyc); end
        end
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 3; i++) begin
            mse = WW'(i + 1); mse_valid = 1'b1; step();
        end
        mse_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_valid_state busy=%0b done=%0b exp 0 0", busy, done); end
        checks++; if (min_mse !== 32'd200 || min_index !== 4'd1 || match !== 1'b1)
            begin failures++; $display("FAIL idle_valid_hold got mse=%0d idx=%0d match=%0b exp 200 1 1", min_mse, min_index, match); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL idle_valid_done got=%0d pulses exp=0", obs_q.size()); end
    endtask

    task automatic test_tie_gaps();
        res_t o;
        bit   got;
        int   lc;
        logic [WW-1:0] tv [0:2];
        tv[0] = 70; tv[1] = 70; tv[2] = 90;
        start = 1'b1; library_size = SW'(3); step(); start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tie_busy_start got=%0b exp=1", busy); end
        lc = cyc;
        for (int i = 0; i < 3; i++) begin
            mse = tv[i]; mse_valid = 1'b1; step(); mse_valid = 1'b0; lc = cyc;
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tie_busy_gap got=%0b exp=1", busy); end
                    step();
                end
            end
        end
        exp_q.push_back('{32'd70, 4'd0, 1'b1, lc});
        wait_obs(20, got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL tie timeout: no done"); void'(exp_q.pop_front());
        end else begin
            res_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.mse !== e.mse || o.idx !== e.idx || o.match !== e.match || o.cyc !== e.cyc)
                begin failures++; $display("FAIL tie got mse=%0d idx=%0d match=%0b cyc=%0d exp mse=%0d idx=%0d match=%0b cyc=%0d", o.mse, o.idx, o.match, o.cyc, e.mse, e.idx, e.match, e.cyc); end
        end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL tie_done_width got=%0b exp=0", done); end
        repeat (3) step();
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL tie_extra_done got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_abort();
        res_t e, o;
        bit   got;
        start = 1'b1; library_size = SW'(4); step(); start = 1'b0;
        mse = 10; mse_valid = 1'b1; step();
        mse = 5; step();
        mse_valid = 1'b0; step();
        // restart with a same-cycle sample that must be discarded
        start = 1'b1; library_size = SW'(2); mse = 1; mse_valid = 1'b1; step();
        start = 1'b0;
        mse = 40; step();
        mse = 30; step();
        mse_valid = 1'b0;
        exp_q.push_back('{32'd30, 4'd1, 1'b1, cyc});
        wait_obs(20, got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL abort timeout: no done"); void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.mse !== e.mse || o.idx !== e.idx || o.match !== e.match || o.cyc !== e.cyc)
                begin failures++; $display("FAIL abort got mse=%0d idx=%0d match=%0b cyc=%0d exp mse=%0d idx=%0d match=%0b cyc=%0d", o.mse, o.idx, o.match, o.cyc, e.mse, e.idx, e.match, e.cyc); end
        end
        repeat (3) step();
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL abort_extra_done got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_size_zero();
        res_t e, o;
        bit   got;
        run_search(0, 0, 0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL size0_flags got done=%0b busy=%0b exp 1 0", done, busy); end
        wait_obs(20, got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL size0 timeout: no done"); void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.mse !== 32'hFFFF_FFFF || o.idx !== 4'd0 || o.match !== 1'b0 || o.cyc !== e.cyc)
                begin failures++; $display("FAIL size0 got mse=%0h idx=%0d match=%0b cyc=%0d exp mse=ffffffff idx=0 match=0 cyc=%0d", o.mse, o.idx, o.match, o.cyc, e.cyc); end
        end
    endtask

    task automatic test_full_library();
        res_t e, o;
        bit   got;
        for (int i = 0; i < 16; i++) vals[i] = WW'(16 - i);
        run_search(16, 16, 0);
        for (int i = 0; i < 16; i++) vals[i] = WW'($urandom_range(1000, 50));
        // oversize request: only the first 16 samples count
        run_search(20, 16, 0);
        mse = 0; mse_valid = 1'b1; step(); step(); mse_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_obs(20, got);
            checks++;
            if (!got) begin
                failures++; $display("FAIL full_%0d timeout: no done", k); void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (k == 0 && (e.mse !== 32'd1 || e.idx !== 4'd15))
                    $display("note: model disagrees with descending expectation");
                if (o.mse !== e.mse || o.idx !== e.idx || o.match !== e.match || o.cyc !== e.cyc)
                    begin failures++; $display("FAIL full_%0d got mse=%0d idx=%0d match=%0b cyc=%0d exp mse=%0d idx=%0d match=%0b cyc=%0d", k, o.mse, o.idx, o.match, o.cyc, e.mse, e.idx, e.match, e.cyc); end
            end
        end
        repeat (3) step();
        checks++; if (obs_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL full_extra got pulses=%0d busy=%0b exp 0 0", obs_q.size(), busy); end
    endtask

    task automatic test_rst_mid_search();
        start = 1'b1; library_size = SW'(4); step(); start = 1'b0;
        mse = 10; mse_valid = 1'b1; step();
        mse = 5; step();
        mse_valid = 1'b0;
        rst = 1'b1; step();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || min_mse !== '0 || min_index !== '0 || match !== 1'b0)
            begin failures++; $display("FAIL rst_mid got busy=%0b done=%0b mse=%0d idx=%0d match=%0b exp all 0", busy, done, min_mse, min_index, match); end
        rst = 1'b0; step();
        mse = 3; mse_valid = 1'b1; step(); step(); mse_valid = 1'b0;
        repeat (2) step();
        checks++; if (busy !== 1'b0 || min_mse !== '0 || obs_q.size() != 0)
            begin failures++; $display("FAIL rst_mid_after got busy=%0b mse=%0d pulses=%0d exp 0 0 0", busy, min_mse, obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        bit   got;
        for (int s = 0; s < 6; s++) begin
            int sz;
            sz = int'($urandom_range(16, 1));
            for (int i = 0; i < sz; i++) vals[i] = WW'($urandom_range(40, 0));
            run_search(sz, sz, 0);
        end
        for (int s = 0; s < 6; s++) begin
            wait_obs(40, got);
            checks++;
            if (!got) begin
                failures++; $display("FAIL b2b_%0d timeout: no done", s); void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.mse !== e.mse || o.idx !== e.idx || o.match !== e.match || o.cyc !== e.cyc)
                    begin failures++; $display("FAIL b2b_%0d got mse=%0d idx=%0d match=%0b cyc=%0d exp mse=%0d idx=%0d match=%0b cyc=%0d", s, o.mse, o.idx, o.match, o.cyc, e.mse, e.idx, e.match, e.cyc); end
            end
        end
    endtask

`ifdef HSI_MSE_THRESHOLD_EN
    task automatic test_threshold();
        res_t e, o;
        bit   got;
        vals[0] = 150; vals[1] = 120;
        threshold = 100;
        run_search(2, 2, 0);
        threshold = 120;
        step();
        run_search(2, 2, 0);
        for (int k = 0; k < 2; k++) begin
            wait_obs(20, got);
            checks++;
            if (!got) begin
                failures++; $display("FAIL thr_%0d timeout: no done", k); void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.mse !== 32'd120 || o.match !== (k == 1) || o.cyc !== e.cyc)
                    begin failures++; $display("FAIL thr_%0d got mse=%0d match=%0b cyc=%0d exp mse=120 match=%0b cyc=%0d", k, o.mse, o.match, o.cyc, (k == 1), e.cyc); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_idle_valid();
        test_tie_gaps();
        test_abort();
        test_size_zero();
        test_full_library();
        test_rst_mid_search();
        test_back_to_back();
`ifdef HSI_MSE_THRESHOLD_EN
        test_threshold();
`endif
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL leftover got expected=%0d observed=%0d exp 0 0", exp_q.size(), obs_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hsi_mse_min_search.md
# hsi_mse_min_search

Downstream consumer of the HSI mean-square-error stage. It receives one MSE result per library pixel compared against a reference pixel. It tracks the smallest MSE and the library index that produced it, then reports the best match once a programmed number of results has been consumed. This block forms the identification decision at the end of the spectral-matching datapath.

## Interface
Parameters:
- WORD_WIDTH, 32, width of each MSE value and of the threshold.
- LIBRARY_SIZE, 16, maximum number of library pixels per search.
- LIBRARY_ADDR, $clog2(LIBRARY_SIZE), width of the library index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse that begins a new search and latches `library_size` (and `threshold` when compiled in).
- library_size  input  LIBRARY_ADDR+1  number of MSE results in this search, 0..LIBRARY_SIZE.
- mse  input  WORD_WIDTH  incoming MSE value.
- mse_valid  input  1  `mse` is valid this cycle; single-cycle qualifier, no backpressure.
- threshold  input  WORD_WIDTH  maximum accepted MSE; present only with HSI_MSE_THRESHOLD_EN.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when the result is final.
- min_mse  output  WORD_WIDTH  smallest MSE seen in the current or last search.
- min_index  output  LIBRARY_ADDR  index, counted from 0 in arrival order, of `min_mse`.
- match  output  1  result qualifier, valid while `done` is high and held afterwards.

## Operation
- FSM states: IDLE, SEARCH, DONE.
  - IDLE, `start`=1 → SEARCH. If `library_size`=0, go to DONE instead.
  - SEARCH, accepted `mse_valid` with count = size-1 → DONE.
  - SEARCH, `start`=1 → restart SEARCH. Abort the running search and discard any `mse_valid` sampled in the same cycle.
  - DONE → IDLE after one cycle. A `start` in DONE behaves as in IDLE.
- On `start`:
  - count ← 0.
  - size ← `library_size`; values above LIBRARY_SIZE saturate to LIBRARY_SIZE.
  - min_mse ← all ones.
  - min_index ← 0.
  - match ← 0.
- In SEARCH, each `mse_valid` does the following:
  - Compare `mse` against min_mse (unsigned).
  - If `mse` < min_mse (strict), update min_mse ← `mse` and min_index ← count.
  - Ties keep the earlier index.
  - count increments.
- `mse_valid` in IDLE or DONE is ignored; no state change.
- `mse_valid` arriving in the same cycle as `start` from IDLE is ignored. The first counted result arrives after the start cycle.
- `match` is computed at the transition to DONE:
  - With size 0: match=0, min_mse=all ones, min_index=0.
  - Otherwise, see Configuration.
- `min_mse`, `min_index` and `match` hold their values from DONE until the next `start`.

## Timing
- Reset values: busy=0, done=0, min_mse=0, min_index=0, match=0, state=IDLE, count=0.
- `busy` rises the cycle after `start` and falls in the cycle `done` is high.
- `done` is high exactly one cycle after the cycle in which the last `mse_valid` is sampled.
- The compare/update has 1-cycle latency: min_mse/min_index reflect a sample the cycle after it is sampled.
- For `start` with `library_size`=0, `done` is high the cycle after `start`.
- `rst` asserted mid-search returns all state to its reset values on the next edge; the partial result is lost.
- Back-to-back `mse_valid` every cycle is supported. Gaps of any length are allowed; there is no timeout.

## Configuration
- HSI_MSE_THRESHOLD_EN defined:
  - The `threshold` port exists and is latched at `start`.
  - At DONE, match = (min_mse <= threshold) and size > 0.
- HSI_MSE_THRESHOLD_EN not defined:
  - There is no `threshold` port.
  - match = (size > 0).

## Test plan
- Basic search: start with size=4, then mse 500, 200, 300, 900 on consecutive cycles → done pulse one cycle after the 4th; min_mse=200, min_index=1, match=1.
- Tie and gaps: size=3, mse 70, 70, 90 with 2 idle cycles between each → min_mse=70, min_index=0. Busy stays high throughout and done is a single cycle.
- Abort: size=4, two samples (10, 5), then start with size=2, then samples 40, 30 → min_mse=30, min_index=1. Done fires only once, after 30.
- Edges:
  - size=0 → done the cycle after start, match=0, min_mse=0xFFFFFFFF.
  - mse_valid in IDLE → no state change.
  - rst mid-search → all outputs 0.
- Threshold (with HSI_MSE_THRESHOLD_EN): threshold=100, size=2, mse 150, 120 → min_mse=120, match=0. Repeating with threshold=120 → match=1.
- Full library: size=16 with values descending 16..1 → min_mse=1, min_index=15. Also start with library_size=20 → saturates, done after 16 samples.
